// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package cache_pkg;

  localparam int IC_SETS_DEFAULT = 16;
  localparam int IC_BLK_WORDS    = 2;
  localparam int IC_WORD_W       = 32;
  // Widest tag occurs at the minimum of two sets; narrower tags are zero-extended.
  localparam int IC_TAG_MAX_W    = IC_WORD_W - 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL0,
    FILL1
  } icache_state_t;

  typedef struct packed {
    logic                    valid;
    logic [IC_TAG_MAX_W-1:0] tag;
    logic [IC_WORD_W-1:0]    word0;
    logic [IC_WORD_W-1:0]    word1;
  } icache_line_t;

endpackage

// File: rtl/icache_fill_fsm.sv
// Miss-fill sequencer: latches the missing block address, issues the two word
// reads to the memory controller and strobes the completed line into the array.
module icache_fill_fsm
  import cache_pkg::*;
#(
  parameter int BLK_W  = 29,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              missReq_i,
  input  logic [BLK_W-1:0]  missBlk_i,
  input  logic              iflush_i,
  input  logic              iwait_i,
  input  logic [WORD_W-1:0] iload_i,
  output logic              idle_o,
  output logic              iREN_o,
  output logic [WORD_W-1:0] iaddr_o,
  output logic              lineWe_o,
  output logic [BLK_W-1:0]  fillBlk_o,
  output logic [WORD_W-1:0] fillWord0_o
);

  icache_state_t     state_q, state_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [WORD_W-1:0] word0_q, word0_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush always wins, so a half-filled line is never installed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (missReq_i && !iflush_i) state_d = FILL0;
      FILL0:   if (iflush_i) state_d = IDLE;
               else if (!iwait_i) state_d = FILL1;
      FILL1:   if (iflush_i || !iwait_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle_o   = 1'b0;
    iREN_o   = 1'b0;
    iaddr_o  = '0;
    lineWe_o = 1'b0;
    unique case (state_q)
      IDLE: idle_o = 1'b1;
      FILL0: begin
        iREN_o  = 1'b1;
        iaddr_o = {blk_q, 1'b0, 2'b00};
      end
      FILL1: begin
        iREN_o   = 1'b1;
        iaddr_o  = {blk_q, 1'b1, 2'b00};
        lineWe_o = !iwait_i && !iflush_i;
      end
      default: idle_o = 1'b0;
    endcase
  end

  always_comb begin
    blk_d   = blk_q;
    word0_d = word0_q;
    if (state_q == IDLE && missReq_i && !iflush_i) begin
      blk_d = missBlk_i;
    end
    if (state_q == FILL0 && !iwait_i) begin
      word0_d = iload_i;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      blk_q   <= '0;
      word0_q <= '0;
    end else begin
      blk_q   <= blk_d;
      word0_q <= word0_d;
    end
  end

  assign fillBlk_o   = blk_q;
  assign fillWord0_o = word0_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache, two-word blocks, same-cycle hits.
// Define ICACHE_PERF_EN to add hit_count / miss_count performance counters.
module icache_dm
  import cache_pkg::*;
#(
  parameter int SETS   = IC_SETS_DEFAULT,
  parameter int WORD_W = IC_WORD_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              iflush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(IC_BLK_WORDS) + 2;
  localparam int TAG_W = WORD_W - IDX_W - OFF_W;
  localparam int BLK_W = WORD_W - OFF_W;

  icache_line_t lines_q [SETS];

  logic [TAG_W-1:0]  reqTag;
  logic [IDX_W-1:0]  reqIdx;
  logic              reqWord;
  logic              unusedByteOff;
  icache_line_t      curLine;
  logic              tagMatch;
  logic              fsmIdle;
  logic              missReq;
  logic              lineWe;
  logic [BLK_W-1:0]  fillBlk;
  logic [WORD_W-1:0] fillWord0;
  logic [IDX_W-1:0]  fillIdx;
  logic [TAG_W-1:0]  fillTag;

  assign reqTag        = imemaddr[WORD_W-1:IDX_W+OFF_W];
  assign reqIdx        = imemaddr[IDX_W+OFF_W-1:OFF_W];
  assign reqWord       = imemaddr[2];
  assign unusedByteOff = ^imemaddr[1:0];

  assign curLine  = lines_q[reqIdx];
  assign tagMatch = curLine.tag == IC_TAG_MAX_W'(reqTag);

  // Hits are only served from IDLE and are suppressed in a flush cycle.
  always_comb begin
    ihit     = fsmIdle && imemREN && !iflush && curLine.valid && tagMatch;
    imemload = '0;
    if (ihit) begin
      imemload = reqWord ? curLine.word1 : curLine.word0;
    end
  end

  assign missReq = fsmIdle && imemREN && !iflush && !(curLine.valid && tagMatch);
  assign fillIdx = fillBlk[IDX_W-1:0];
  assign fillTag = fillBlk[BLK_W-1:IDX_W];

  icache_fill_fsm #(
    .BLK_W  (BLK_W),
    .WORD_W (WORD_W)
  ) u_fill (
    .CLK         (CLK),
    .nRST        (nRST),
    .missReq_i   (missReq),
    .missBlk_i   (imemaddr[WORD_W-1:OFF_W]),
    .iflush_i    (iflush),
    .iwait_i     (iwait),
    .iload_i     (iload),
    .idle_o      (fsmIdle),
    .iREN_o      (iREN),
    .iaddr_o     (iaddr),
    .lineWe_o    (lineWe),
    .fillBlk_o   (fillBlk),
    .fillWord0_o (fillWord0)
  );

  // Only the valid bits are reset; tag and data are qualified by them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        lines_q[i].valid <= 1'b0;
      end
    end else if (iflush) begin
      for (int i = 0; i < SETS; i++) begin
        lines_q[i].valid <= 1'b0;
      end
    end else if (lineWe) begin
      lines_q[fillIdx] <= '{valid: 1'b1,
                            tag:   IC_TAG_MAX_W'(fillTag),
                            word0: fillWord0,
                            word1: iload};
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hitCnt_q, missCnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hitCnt_q  <= '0;
      missCnt_q <= '0;
    end else begin
      if (ihit) begin
        hitCnt_q <= hitCnt_q + 32'd1;
      end
      if (missReq) begin
        missCnt_q <= missCnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hitCnt_q;
  assign miss_count = missCnt_q;
`endif

endmodule
